// File: rtl/eth_pkg.sv
// eth_pkg: shared Ethernet framing constants and the tx header-insert state encoding.
package eth_pkg;
    localparam int ETH_HDR_LEN = 14;
    localparam int ETH_MAC_W = 48;
    localparam int ETH_TYPE_W = 16;
    typedef enum logic [1:0] {TX_HDR_IDLE, TX_HDR_HEADER, TX_HDR_PAYLOAD} tx_hdr_state_e;
endpackage

// File: rtl/eth_tx_hdr_insert.sv
// eth_tx_hdr_insert: prepends the 14-byte Ethernet header to a payload stream for the MAC tx_axis;
// preamble, padding and FCS are left to the MAC.
module eth_tx_hdr_insert
    import eth_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_hdr_valid,
    output logic                  s_hdr_ready,
    input  logic [ETH_MAC_W-1:0]  s_eth_dest_mac,
    input  logic [ETH_MAC_W-1:0]  s_eth_src_mac,
    input  logic [ETH_TYPE_W-1:0] s_eth_type,
    input  logic [7:0]            s_payload_axis_tdata,
    input  logic                  s_payload_axis_tvalid,
    output logic                  s_payload_axis_tready,
    input  logic                  s_payload_axis_tlast,
    input  logic                  s_payload_axis_tuser,
    output logic [7:0]            m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic                  busy
);
    localparam int HDR_W = ETH_HDR_LEN * 8;
    tx_hdr_state_e state, state_d;
    logic [3:0] hdr_cnt;
    logic [HDR_W-1:0] hdr_q;
    logic slot_free, hdr_fire, hdr_load, hdr_done, pay_fire;
    assign slot_free = !m_axis_tvalid || m_axis_tready;
    assign hdr_fire = state == TX_HDR_IDLE && s_hdr_valid && s_hdr_ready;
    assign hdr_load = state == TX_HDR_HEADER && slot_free;
    assign hdr_done = hdr_load && hdr_cnt == 4'(ETH_HDR_LEN - 1);
    assign s_payload_axis_tready = state == TX_HDR_PAYLOAD && slot_free;
    assign pay_fire = s_payload_axis_tvalid && s_payload_axis_tready;
    assign busy = state != TX_HDR_IDLE || m_axis_tvalid;
    always_comb begin
        state_d = state;
        if (hdr_fire) state_d = TX_HDR_HEADER;
        if (hdr_done) state_d = TX_HDR_PAYLOAD;
        if (pay_fire && s_payload_axis_tlast) state_d = TX_HDR_IDLE;
    end
    // header is held MSB-first and shifted out one byte per free output slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= TX_HDR_IDLE;
            hdr_cnt <= '0;
            hdr_q <= '0;
            s_hdr_ready <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata <= '0;
            m_axis_tlast <= 1'b0;
            m_axis_tuser <= 1'b0;
        end else begin
            state <= state_d;
            s_hdr_ready <= state_d == TX_HDR_IDLE;
            if (hdr_fire) begin
                hdr_q <= {s_eth_dest_mac, s_eth_src_mac, s_eth_type};
                hdr_cnt <= '0;
            end else if (hdr_load) begin
                hdr_q <= hdr_q << 8;
                hdr_cnt <= hdr_done ? hdr_cnt : hdr_cnt + 4'd1;
            end
            if (hdr_load) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata <= hdr_q[HDR_W-1 -: 8];
                m_axis_tlast <= 1'b0;
                m_axis_tuser <= 1'b0;
            end else if (pay_fire) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata <= s_payload_axis_tdata;
                m_axis_tlast <= s_payload_axis_tlast;
                m_axis_tuser <= s_payload_axis_tuser;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_eth_tx_hdr_insert.sv
// tb_eth_tx_hdr_insert: frame table plus random frames checked against a byte-queue model of the framed output.
module tb_eth_tx_hdr_insert;
    import eth_pkg::*;
    logic clk = 1'b0, rst_n = 1'b0;
    logic s_hdr_valid = 1'b0, s_hdr_ready;
    logic [47:0] s_eth_dest_mac = '0, s_eth_src_mac = '0;
    logic [15:0] s_eth_type = '0;
    logic [7:0] s_payload_axis_tdata = '0;
    logic s_payload_axis_tvalid = 1'b0, s_payload_axis_tready;
    logic s_payload_axis_tlast = 1'b0, s_payload_axis_tuser = 1'b0;
    logic [7:0] m_axis_tdata;
    logic m_axis_tvalid, m_axis_tready = 1'b0, m_axis_tlast, m_axis_tuser, busy;

    typedef struct {
        logic [47:0] dest;
        logic [47:0] src;
        logic [15:0] typ;
        int plen;
        int base;
        logic abort;
        logic rnd;
        logic b2b;
        int exp_len;
    } frame_t;
    typedef struct {logic [7:0] d; logic l; logic u;} beat_t;

    frame_t tbl[14];
    frame_t rf;
    beat_t exp_q[$];
    int tests = 0, fails = 0, cyc = 0, mf = 0, out_idx = 0;
    int h_cyc[32], f_len[32];
    int f_first[32] = '{default: -1};
    int f_pay0[32] = '{default: -1};
    int f_last[32] = '{default: -1};
    logic rnd_ready = 1'b0, prev_stall = 1'b0;
    logic [9:0] prev_beat = '0;

    eth_tx_hdr_insert dut (
        .clk(clk), .rst_n(rst_n),
        .s_hdr_valid(s_hdr_valid), .s_hdr_ready(s_hdr_ready),
        .s_eth_dest_mac(s_eth_dest_mac), .s_eth_src_mac(s_eth_src_mac), .s_eth_type(s_eth_type),
        .s_payload_axis_tdata(s_payload_axis_tdata), .s_payload_axis_tvalid(s_payload_axis_tvalid),
        .s_payload_axis_tready(s_payload_axis_tready), .s_payload_axis_tlast(s_payload_axis_tlast),
        .s_payload_axis_tuser(s_payload_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .busy(busy)
    );

    always #4 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        #1 m_axis_tready = rnd_ready ? 1'($urandom_range(1)) : 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // the expected frame: header fields MSB-first, then the payload bytes
    task automatic model_frame(input frame_t f);
        logic [111:0] hdr;
        hdr = {f.dest, f.src, f.typ};
        for (int k = 0; k < ETH_HDR_LEN; k++)
            exp_q.push_back('{8'(hdr >> (8 * (ETH_HDR_LEN - 1 - k))), 1'b0, 1'b0});
        for (int k = 0; k < f.plen; k++)
            exp_q.push_back('{8'(f.base + k), k == f.plen - 1, f.abort && k == f.plen - 1});
    endtask

    always @(negedge clk) begin : mon
        beat_t e;
        if (!rst_n) begin
            out_idx = 0;
            prev_stall = 1'b0;
            f_first[mf] = -1;
            f_pay0[mf] = -1;
        end else begin
            if (prev_stall) chk("hold", 32'({m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser}), 32'({1'b1, prev_beat}));
            if (m_axis_tvalid && f_first[mf] < 0) f_first[mf] = cyc;
            if (m_axis_tvalid && out_idx == ETH_HDR_LEN && f_pay0[mf] < 0) f_pay0[mf] = cyc;
            if (s_payload_axis_tready) chk("early_tready", 32'(out_idx + int'(m_axis_tvalid) >= ETH_HDR_LEN), 32'd1);
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_beat: got %0h expected none (cycle %0d)", m_axis_tdata, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", 32'({m_axis_tdata, m_axis_tlast, m_axis_tuser}), 32'({e.d, e.l, e.u}));
                end
                out_idx++;
                if (m_axis_tlast) begin
                    f_last[mf] = cyc;
                    f_len[mf] = out_idx;
                    mf++;
                    out_idx = 0;
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_beat = {m_axis_tdata, m_axis_tlast, m_axis_tuser};
        end
    end

    task automatic send_hdr(input int i, input frame_t f);
        s_hdr_valid = 1'b1;
        s_eth_dest_mac = f.dest;
        s_eth_src_mac = f.src;
        s_eth_type = f.typ;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (s_hdr_ready) begin
                @(posedge clk);
                #1 h_cyc[i] = cyc;
                break;
            end
            if (n == 1000) begin
                fails++;
                $display("FAIL hdr_timeout: got no s_hdr_ready expected handshake (frame %0d)", i);
                break;
            end
        end
        s_hdr_valid = 1'b0;
        s_eth_dest_mac = 48'({$urandom(), $urandom()});
        s_eth_src_mac = 48'({$urandom(), $urandom()});
        s_eth_type = 16'($urandom());
    endtask

    task automatic send_pay(input frame_t f);
        logic ok;
        for (int k = 0; k < f.plen; k++) begin
            if (f.rnd && $urandom_range(2) == 0) begin
                s_payload_axis_tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
            s_payload_axis_tvalid = 1'b1;
            s_payload_axis_tdata = 8'(f.base + k);
            s_payload_axis_tlast = k == f.plen - 1;
            s_payload_axis_tuser = f.abort && k == f.plen - 1;
            for (int n = 0; ; n++) begin
                @(negedge clk);
                ok = s_payload_axis_tready;
                @(posedge clk);
                #1;
                if (ok) break;
                if (n == 1000) begin
                    fails++;
                    $display("FAIL pay_timeout: got no tready expected accept (byte %0d)", k);
                    break;
                end
            end
        end
        s_payload_axis_tvalid = 1'b0;
        s_payload_axis_tlast = 1'b0;
        s_payload_axis_tuser = 1'b0;
    endtask

    task automatic run_frame(input int i, input frame_t f);
        rnd_ready = f.rnd;
        model_frame(f);
        fork
            send_hdr(i, f);
            send_pay(f);
        join
    endtask

    task automatic drain();
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) break;
            if (n == 1000) begin
                fails++;
                $display("FAIL drain_timeout: got %0d beats left expected 0", exp_q.size());
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input int i, input frame_t f);
        chk("frame_len", f_len[i], f.exp_len);
        if (!f.rnd) begin
            chk("first_byte_latency", f_first[i] - h_cyc[i], 1);
            chk("payload0_cycle", f_pay0[i] - f_first[i], ETH_HDR_LEN);
        end
        if (f.b2b) chk("b2b_gap", f_first[i] - f_last[i-1], 2);
    endtask

    initial begin
        tbl[0] = '{48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h0800, 46, 0, 1'b0, 1'b0, 1'b0, 60};
        tbl[1] = '{48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h0800, 46, 0, 1'b0, 1'b1, 1'b0, 60};
        tbl[2] = '{48'h0011_2233_4455, 48'h0266_7788_99AA, 16'h86DD, 2, 8'h40, 1'b0, 1'b0, 1'b0, 16};
        tbl[3] = '{48'hA1A2_A3A4_A5A6, 48'h0200_0000_0002, 16'h0806, 3, 8'h80, 1'b0, 1'b0, 1'b1, 17};
        tbl[4] = '{48'h0102_0304_0506, 48'h0A0B_0C0D_0E0F, 16'h88B5, 5, 8'hF0, 1'b1, 1'b0, 1'b0, 19};
        tbl[5] = '{48'h5A5A_5A5A_5A5A, 48'hA5A5_A5A5_A5A5, 16'h0001, 1, 8'h7E, 1'b0, 1'b0, 1'b0, 15};
        for (int i = 6; i < 14; i++) begin
            tbl[i].dest = 48'({$urandom(), $urandom()});
            tbl[i].src = 48'({$urandom(), $urandom()});
            tbl[i].typ = 16'($urandom());
            tbl[i].plen = int'($urandom_range(20, 1));
            tbl[i].base = int'($urandom_range(255));
            tbl[i].abort = 1'($urandom_range(1));
            tbl[i].rnd = 1'($urandom_range(1));
            tbl[i].b2b = 1'b0;
            tbl[i].exp_len = ETH_HDR_LEN + tbl[i].plen;
        end
        rf = '{48'hDEAD_BEEF_0001, 48'h0200_CAFE_0002, 16'h0800, 4, 8'h10, 1'b0, 1'b0, 1'b0, 18};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 32'({s_hdr_ready, s_payload_axis_tready, m_axis_tvalid, m_axis_tdata,
                                  m_axis_tlast, m_axis_tuser, busy}), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_before_edge", 32'(s_hdr_ready), 32'd0);
        @(negedge clk);
        chk("ready_after_release", 32'(s_hdr_ready), 32'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) begin
            run_frame(i, tbl[i]);
            if (i == 13 || !tbl[i+1].b2b) drain();
        end
        for (int i = 0; i < 14; i++) check_frame(i, tbl[i]);

        // abandon a frame mid-header, then send a clean frame into the same slot
        rnd_ready = 1'b0;
        model_frame(rf);
        send_hdr(14, rf);
        for (int n = 0; out_idx < 7; n++) begin
            @(negedge clk);
            if (n == 200) begin
                fails++;
                $display("FAIL byte7_timeout: got %0d beats expected 7", out_idx);
                break;
            end
        end
        #2 rst_n = 1'b0;
        #1 chk("midreset_outputs", 32'({s_hdr_ready, s_payload_axis_tready, m_axis_tvalid, m_axis_tdata,
                                         m_axis_tlast, m_axis_tuser, busy}), 32'd0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midreset_ready_low", 32'(s_hdr_ready), 32'd0);
        @(negedge clk);
        chk("midreset_ready_high", 32'(s_hdr_ready), 32'd1);
        @(posedge clk);
        #1;
        run_frame(14, rf);
        drain();
        check_frame(14, rf);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
